// File: rtl/aurora_hls_link_ctrl.sv
// Bring-up / recovery sequencer for one Aurora 64B/66B quad-lane core.
// Optional macro AURORA_HLS_LINK_CTRL_HARD_ERR_EN: treat hard error as a link drop.
module aurora_hls_link_ctrl #(
   parameter int unsigned PMA_INIT_CYCLES   = 256,
   parameter int unsigned RESET_PB_CYCLES   = 128,
   parameter int unsigned STABLE_CYCLES     = 1024,
   parameter int unsigned UP_TIMEOUT_CYCLES = 32'd1 << 24,
   parameter int unsigned MAX_RETRIES       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [12:0] aurora_status,
   output logic        pma_init,
   output logic        reset_pb,
   output logic        link_ready,
   output logic        link_failed,
   output logic [31:0] retry_count,
   output logic [2:0]  state
);

   localparam int unsigned PW = $clog2(PMA_INIT_CYCLES + 1);
   localparam int unsigned RW = $clog2(RESET_PB_CYCLES + 1);
   localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TW = $clog2(UP_TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      RESET_PMA   = 3'd1,
      RELEASE_PMA = 3'd2,
      WAIT_UP     = 3'd3,
      UP          = 3'd4,
      FAILED      = 3'd5
   } st_t;

   st_t cur_st, nxt_st;

   logic [12:0]   s_meta, s;
   logic [PW-1:0] pma_cnt;
   logic [RW-1:0] rel_cnt;
   logic [SW-1:0] stab_cnt;
   logic [TW-1:0] to_cnt;
   logic [31:0]   retry_inc;
   logic          status_ok, hard_err, ok_wait;
   logic          do_retry, clr_retry;
   logic          unused_soft_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_meta <= '0;
         s      <= '0;
      end else begin
         s_meta <= aurora_status;
         s      <= s_meta;
      end
   end

   assign status_ok = (s[3:0] == 4'hF) & (s[7:4] == 4'hF) & s[8] & ~s[9] & s[12];
`ifdef AURORA_HLS_LINK_CTRL_HARD_ERR_EN
   assign hard_err = s[10];
   assign unused_soft_err = s[11];
`else
   assign hard_err = 1'b0;
   assign unused_soft_err = ^s[11:10];
`endif
   assign ok_wait   = status_ok & ~hard_err;
   assign retry_inc = (retry_count == '1) ? retry_count : retry_count + 32'd1;

   always_comb begin
      nxt_st    = cur_st;
      do_retry  = 1'b0;
      clr_retry = 1'b0;
      if (!enable) begin
         nxt_st = IDLE;
      end else begin
         case (cur_st)
            IDLE: begin
               nxt_st    = RESET_PMA;
               clr_retry = 1'b1;
            end
            RESET_PMA:
               if (pma_cnt == PW'(PMA_INIT_CYCLES - 1)) nxt_st = RELEASE_PMA;
            RELEASE_PMA:
               if (rel_cnt == RW'(RESET_PB_CYCLES - 1)) nxt_st = WAIT_UP;
            WAIT_UP: begin
               // Stable completion is checked first so it wins over a same-cycle timeout.
               if (ok_wait && stab_cnt == SW'(STABLE_CYCLES - 1)) nxt_st = UP;
               else if (to_cnt == TW'(UP_TIMEOUT_CYCLES - 1))     do_retry = 1'b1;
            end
            UP:
               if (!ok_wait) do_retry = 1'b1;
            FAILED:
               nxt_st = FAILED;
            default:
               nxt_st = IDLE;
         endcase
         if (do_retry)
            nxt_st = (MAX_RETRIES != 0 && retry_inc >= MAX_RETRIES) ? FAILED : RESET_PMA;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_st      <= IDLE;
         pma_cnt     <= '0;
         rel_cnt     <= '0;
         stab_cnt    <= '0;
         to_cnt      <= '0;
         retry_count <= '0;
      end else begin
         cur_st   <= nxt_st;
         // Counters run only while staying in their state, so every entry starts at zero.
         pma_cnt  <= (cur_st == RESET_PMA && nxt_st == RESET_PMA) ? pma_cnt + 1'b1 : '0;
         rel_cnt  <= (cur_st == RELEASE_PMA && nxt_st == RELEASE_PMA) ? rel_cnt + 1'b1 : '0;
         stab_cnt <= (cur_st == WAIT_UP && nxt_st == WAIT_UP && ok_wait) ? stab_cnt + 1'b1 : '0;
         to_cnt   <= (cur_st == WAIT_UP && nxt_st == WAIT_UP) ? to_cnt + 1'b1 : '0;
         if (clr_retry)     retry_count <= '0;
         else if (do_retry) retry_count <= retry_inc;
      end
   end

   always_comb begin
      pma_init    = 1'b0;
      reset_pb    = 1'b0;
      link_ready  = 1'b0;
      link_failed = 1'b0;
      case (cur_st)
         IDLE, RESET_PMA: begin
            pma_init = 1'b1;
            reset_pb = 1'b1;
         end
         RELEASE_PMA: reset_pb = 1'b1;
         UP:          link_ready = 1'b1;
         FAILED: begin
            pma_init    = 1'b1;
            reset_pb    = 1'b1;
            link_failed = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = cur_st;

endmodule

// File: tb/tb_aurora_hls_link_ctrl.sv
// Directed self-checking bench for aurora_hls_link_ctrl (PMA=4, RPB=3, STABLE=5, TIMEOUT=20, RETRIES=2).
module tb_aurora_hls_link_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [12:0] aurora_status;
   logic        pma_init, reset_pb, link_ready, link_failed;
   logic [31:0] retry_count;
   logic [2:0]  state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aurora_hls_link_ctrl #(
      .PMA_INIT_CYCLES  (4),
      .RESET_PB_CYCLES  (3),
      .STABLE_CYCLES    (5),
      .UP_TIMEOUT_CYCLES(20),
      .MAX_RETRIES      (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .aurora_status(aurora_status),
      .pma_init     (pma_init),
      .reset_pb     (reset_pb),
      .link_ready   (link_ready),
      .link_failed  (link_failed),
      .retry_count  (retry_count),
      .state        (state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic restart(input logic [12:0] st);
      enable        = 1'b0;
      aurora_status = st;
      repeat (3) tick();
      enable = 1'b1;
   endtask

   task automatic test_reset();
      logic [5:0] obs;
      rst_n = 1'b0; enable = 1'b0; aurora_status = 13'h11FF;
      #12;
      obs = {state, pma_init, reset_pb, link_ready};
      total++;
      if (obs !== 6'b000_110) begin
         bad++; $display("FAIL reset_outputs got=%b exp=%b", obs, 6'b000_110);
      end
      total++;
      if ({link_failed, retry_count} !== 33'd0) begin
         bad++; $display("FAIL reset_fail_retry got=%b/%0d exp=0/0", link_failed, retry_count);
      end
      tick(); rst_n = 1'b1;
      tick(); tick();
      total++;
      if (state !== 3'd0) begin
         bad++; $display("FAIL idle_hold state got=%0d exp=0", state);
      end
   endtask

   task automatic test_bringup();
      logic [2:0] es;
      logic [5:0] obs, exp_v;
      enable = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         tick();
         es = (e <= 4) ? 3'd1 : (e <= 7) ? 3'd2 : (e <= 12) ? 3'd3 : 3'd4;
         exp_v = {es, (es == 3'd1), (es <= 3'd2), (es == 3'd4)};
         obs   = {state, pma_init, reset_pb, link_ready};
         total++;
         if (obs !== exp_v) begin
            bad++; $display("FAIL bringup e=%0d got=%b exp=%b", e, obs, exp_v);
         end
      end
      total++;
      if (retry_count !== 32'd0) begin
         bad++; $display("FAIL bringup_retry got=%0d exp=0", retry_count);
      end
   endtask

   task automatic test_link_loss();
      aurora_status = 13'h01FF;
      tick();
      aurora_status = 13'h11FF;
      total++;
      if (link_ready !== 1'b1) begin
         bad++; $display("FAIL loss_edge1 link_ready got=%b exp=1", link_ready);
      end
      tick();
      total++;
      if (link_ready !== 1'b1) begin
         bad++; $display("FAIL loss_edge2 link_ready got=%b exp=1", link_ready);
      end
      tick();
      total++;
      if ({link_ready, state, retry_count} !== {1'b0, 3'd1, 32'd1}) begin
         bad++; $display("FAIL loss_edge3 got lr=%b st=%0d rc=%0d exp lr=0 st=1 rc=1",
                         link_ready, state, retry_count);
      end
      repeat (11) tick();
      total++;
      if (state !== 3'd3) begin
         bad++; $display("FAIL loss_reseq_wait state got=%0d exp=3", state);
      end
      tick();
      total++;
      if ({state, link_ready, retry_count} !== {3'd4, 1'b1, 32'd1}) begin
         bad++; $display("FAIL loss_reseq_up got st=%0d lr=%b rc=%0d exp st=4 lr=1 rc=1",
                         state, link_ready, retry_count);
      end
   endtask

   task automatic test_async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({state, pma_init, reset_pb, link_ready, link_failed} !== 7'b000_1100) begin
         bad++; $display("FAIL areset_outputs got st=%0d pi=%b rp=%b lr=%b lf=%b exp 0/1/1/0/0",
                         state, pma_init, reset_pb, link_ready, link_failed);
      end
      total++;
      if (retry_count !== 32'd0) begin
         bad++; $display("FAIL areset_retry got=%0d exp=0", retry_count);
      end
      tick();
      rst_n = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         tick();
         if (e == 1) begin
            total++;
            if (state !== 3'd1) begin
               bad++; $display("FAIL areset_restart state got=%0d exp=1", state);
            end
         end else if (e == 12) begin
            total++;
            if (state !== 3'd3) begin
               bad++; $display("FAIL areset_e12 state got=%0d exp=3", state);
            end
         end else if (e == 13) begin
            total++;
            if (link_ready !== 1'b1) begin
               bad++; $display("FAIL areset_up link_ready got=%b exp=1", link_ready);
            end
         end
      end
   endtask

   task automatic test_glitch();
      restart(13'h11FF);
      repeat (8) tick();
      total++;
      if (state !== 3'd3) begin
         bad++; $display("FAIL glitch_wait state got=%0d exp=3", state);
      end
      tick();
      aurora_status = 13'h01FF;
      tick();
      aurora_status = 13'h11FF;
      repeat (3) tick();
      total++;
      if (state !== 3'd3) begin
         bad++; $display("FAIL glitch_e13 state got=%0d exp=3", state);
      end
      repeat (3) tick();
      total++;
      if (state !== 3'd3) begin
         bad++; $display("FAIL glitch_e16 state got=%0d exp=3", state);
      end
      tick();
      total++;
      if ({state, link_ready} !== {3'd4, 1'b1}) begin
         bad++; $display("FAIL glitch_e17 got st=%0d lr=%b exp st=4 lr=1", state, link_ready);
      end
   endtask

   task automatic test_timeout_fail();
      restart(13'h01FF);
      repeat (27) tick();
      total++;
      if (state !== 3'd3) begin
         bad++; $display("FAIL to_e27 state got=%0d exp=3", state);
      end
      tick();
      total++;
      if ({state, retry_count} !== {3'd1, 32'd1}) begin
         bad++; $display("FAIL to_first_retry got st=%0d rc=%0d exp st=1 rc=1", state, retry_count);
      end
      repeat (26) tick();
      total++;
      if (state !== 3'd3) begin
         bad++; $display("FAIL to_e54 state got=%0d exp=3", state);
      end
      tick();
      total++;
      if ({state, link_failed, pma_init, reset_pb, link_ready} !== {3'd5, 4'b1110}) begin
         bad++; $display("FAIL to_failed got st=%0d lf=%b pi=%b rp=%b lr=%b exp 5/1/1/1/0",
                         state, link_failed, pma_init, reset_pb, link_ready);
      end
      total++;
      if (retry_count !== 32'd2) begin
         bad++; $display("FAIL to_failed_retry got=%0d exp=2", retry_count);
      end
      repeat (5) tick();
      total++;
      if (state !== 3'd5) begin
         bad++; $display("FAIL failed_hold state got=%0d exp=5", state);
      end
      enable = 1'b0;
      tick();
      total++;
      if ({state, link_failed, retry_count} !== {3'd0, 1'b0, 32'd2}) begin
         bad++; $display("FAIL failed_exit got st=%0d lf=%b rc=%0d exp st=0 lf=0 rc=2",
                         state, link_failed, retry_count);
      end
   endtask

   task automatic test_hard_err();
      restart(13'h11FF);
      tick();
      total++;
      if (retry_count !== 32'd0) begin
         bad++; $display("FAIL herr_retry_clear got=%0d exp=0", retry_count);
      end
      repeat (12) tick();
      total++;
      if (state !== 3'd4) begin
         bad++; $display("FAIL herr_up state got=%0d exp=4", state);
      end
      aurora_status = 13'h15FF;
      tick();
      aurora_status = 13'h11FF;
      tick(); tick();
`ifdef AURORA_HLS_LINK_CTRL_HARD_ERR_EN
      total++;
      if ({state, retry_count} !== {3'd1, 32'd1}) begin
         bad++; $display("FAIL herr_retry got st=%0d rc=%0d exp st=1 rc=1", state, retry_count);
      end
`else
      total++;
      if ({state, link_ready, retry_count} !== {3'd4, 1'b1, 32'd0}) begin
         bad++; $display("FAIL herr_ignored got st=%0d lr=%b rc=%0d exp st=4 lr=1 rc=0",
                         state, link_ready, retry_count);
      end
      tick(); tick();
      total++;
      if (link_ready !== 1'b1) begin
         bad++; $display("FAIL herr_ignored_hold link_ready got=%b exp=1", link_ready);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_link_loss();
      test_async_reset();
      test_glitch();
      test_timeout_fail();
      test_hard_err();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
